// File: rtl/keypad_pkg.sv
// keypad_pkg
//   Shared definitions for the 4x4 keypad front end.
//   - key code constants (hex codes reported on key_code)
//   - scanner FSM state encoding
//   - helpers: row/column -> key code lookup, one-low detection, low-bit index
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2
  } scan_state_t;

  localparam logic [3:0] KEY_A    = 4'hA;
  localparam logic [3:0] KEY_B    = 4'hB;
  localparam logic [3:0] KEY_C    = 4'hC;
  localparam logic [3:0] KEY_D    = 4'hD;
  localparam logic [3:0] KEY_E    = 4'hE;
  localparam logic [3:0] KEY_F    = 4'hF;
  localparam logic [3:0] KEY_BKSP = KEY_E;
  localparam logic [3:0] KEY_ENT  = KEY_F;
  localparam logic [3:0] KEY_CLR  = KEY_A;

  localparam logic [3:0] COL_IDLE = 4'hF;
  localparam logic [3:0] ROW_INIT = 4'b1110;

  // Physical layout:
  //   r0: 1 2 3 A
  //   r1: 4 5 6 B
  //   r2: 7 8 9 C
  //   r3: E 0 F D   (E = '*', F = '#')
  function automatic logic [3:0] key_lut(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    code = 4'h0;
    case ({row, col})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = KEY_A;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = KEY_B;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = KEY_C;
      4'b11_00: code = KEY_E;
      4'b11_01: code = 4'h0;
      4'b11_10: code = KEY_F;
      4'b11_11: code = KEY_D;
      default:  code = 4'h0;
    endcase
    return code;
  endfunction

  // True when exactly one bit of an active-low vector is asserted.
  function automatic logic single_low(input logic [3:0] v);
    logic res;
    res = 1'b0;
    case (v)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: res = 1'b1;
      default:                            res = 1'b0;
    endcase
    return res;
  endfunction

  // Index of the lowest zero bit; only meaningful for single-low vectors.
  function automatic logic [1:0] low_index(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    if (!v[0])      idx = 2'd0;
    else if (!v[1]) idx = 2'd1;
    else if (!v[2]) idx = 2'd2;
    else if (!v[3]) idx = 2'd3;
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Row drive, column synchronizer, scan tick divider and press/release
//   debounce for a 4x4 active-low matrix keypad.
// Ports
//   clk        in   system clock
//   rst        in   synchronous reset, active-high
//   col_in     in   [3:0] keypad columns, active-low, asynchronous
//   row_out    out  [3:0] keypad rows, active-low, exactly one bit low
//   key_code   out  [3:0] last decoded key, held until the next press
//   key_valid  out  one-cycle pulse per debounced press
//
// state    | meaning
// ---------+---------------------------------------------------------------
// SCAN     | rows rotate each tick while no single column is low
// DEBOUNCE | row held, counting ticks with the latched column pattern stable
// PRESSED  | key reported, row held, counting ticks of all columns released
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int CLK_HZ         = 100_000_000,
  parameter int SCAN_HZ        = 1000,
  parameter int DEBOUNCE_SCANS = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [3:0] key_code,
  output logic       key_valid
);

  localparam int TICK_DIV = CLK_HZ / SCAN_HZ;
  localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_RELOAD = TW'(TICK_DIV - 1);
  localparam logic [TW-1:0] TICK_ONE    = TW'(1);

  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_SCANS);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  // Two-stage synchronizer; idle columns read as all-high through reset.
  logic [3:0] col_meta;
  logic [3:0] col_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      col_meta <= COL_IDLE;
      col_s    <= COL_IDLE;
    end else begin
      col_meta <= col_in;
      col_s    <= col_meta;
    end
  end

  // Down-counter tick: the strobe fires on terminal count, so the first
  // cycle out of reset is a tick.
  logic [TW-1:0] tick_cnt;
  logic          tick;

  assign tick = (tick_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst)       tick_cnt <= '0;
    else if (tick) tick_cnt <= TICK_RELOAD;
    else           tick_cnt <= tick_cnt - TICK_ONE;
  end

  scan_state_t   state_q, state_d;
  logic [3:0]    row_q, row_d;
  logic [3:0]    latch_q, latch_d;
  logic [3:0]    code_q, code_d;
  logic          valid_q, valid_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;
  logic [3:0]    row_rot;

  assign cnt_inc = cnt_q + CNT_ONE;
  assign row_rot = {row_q[2:0], row_q[3]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SCAN;
      row_q   <= ROW_INIT;
      latch_q <= COL_IDLE;
      code_q  <= 4'h0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      latch_q <= latch_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    latch_d = latch_q;
    code_d  = code_q;
    valid_d = 1'b0;
    cnt_d   = cnt_q;

    if (tick) begin
      case (state_q)
        SCAN: begin
          if (single_low(col_s)) begin
            latch_d = col_s;
            cnt_d   = CNT_ONE;
            state_d = DEBOUNCE;
          end else begin
            // Idle, or several columns low on one row (ghosting): keep scanning.
            row_d = row_rot;
          end
        end

        DEBOUNCE: begin
          if (col_s == latch_q) begin
            if (cnt_inc == CNT_DONE) begin
              state_d = PRESSED;
              cnt_d   = '0;
              valid_d = 1'b1;
              code_d  = key_lut(low_index(row_q), low_index(latch_q));
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            // Bounce: retry on the same row from scratch.
            state_d = SCAN;
            cnt_d   = '0;
          end
        end

        PRESSED: begin
          if (col_s == COL_IDLE) begin
            if (cnt_inc == CNT_DONE) begin
              state_d = SCAN;
              cnt_d   = '0;
              row_d   = row_rot;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            cnt_d = '0;
          end
        end

        default: begin
          state_d = SCAN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign row_out   = row_q;
  assign key_code  = code_q;
  assign key_valid = valid_q;

endmodule

// File: rtl/keypad_freq_entry.sv
// keypad_freq_entry
//   Keypad front end that assembles up to four decimal digits into a
//   frequency setpoint (0..9999 Hz). Digits shift in from the right,
//   E backspaces, A clears, F commits the value to freq_set.
// Ports
//   clk             in   system clock
//   rst             in   synchronous reset, active-high
//   col_in          in   [3:0]  keypad columns, active-low, asynchronous
//   row_out         out  [3:0]  keypad rows, active-low, one bit low
//   key_code        out  [3:0]  last decoded key
//   key_valid       out  one-cycle pulse per debounced press
//   entry           out  [15:0] value being typed, for the display path
//   freq_set        out  [15:0] committed setpoint
//   freq_set_valid  out  one-cycle pulse when freq_set is updated
module keypad_freq_entry
  import keypad_pkg::*;
#(
  parameter int CLK_HZ         = 100_000_000,
  parameter int SCAN_HZ        = 1000,
  parameter int DEBOUNCE_SCANS = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  col_in,
  output logic [3:0]  row_out,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic [15:0] entry,
  output logic [15:0] freq_set,
  output logic        freq_set_valid
);

  keypad_scanner #(
    .CLK_HZ         (CLK_HZ),
    .SCAN_HZ        (SCAN_HZ),
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) u_scanner (
    .clk       (clk),
    .rst       (rst),
    .col_in    (col_in),
    .row_out   (row_out),
    .key_code  (key_code),
    .key_valid (key_valid)
  );

  logic [2:0]  ndig;
  logic [15:0] entry_shift;
  logic        is_digit;

  // At most 4 digits are accepted, so entry never exceeds 9999 and the
  // 17-bit multiply-add always fits back into 16 bits.
  assign entry_shift = 16'(({1'b0, entry} * 17'd10) + {13'd0, key_code});
  assign is_digit    = (key_code <= 4'd9);

  always_ff @(posedge clk) begin
    if (rst) begin
      entry          <= 16'd0;
      ndig           <= 3'd0;
      freq_set       <= 16'd0;
      freq_set_valid <= 1'b0;
    end else begin
      freq_set_valid <= 1'b0;
      if (key_valid) begin
        if (is_digit) begin
          if (ndig < 3'd4) begin
            entry <= entry_shift;
            ndig  <= ndig + 3'd1;
          end
        end else begin
          case (key_code)
            KEY_BKSP: begin
              entry <= entry / 16'd10;
              if (ndig != 3'd0) ndig <= ndig - 3'd1;
            end
            KEY_CLR: begin
              entry <= 16'd0;
              ndig  <= 3'd0;
            end
            KEY_ENT: begin
              freq_set       <= entry;
              freq_set_valid <= 1'b1;
              entry          <= 16'd0;
              ndig           <= 3'd0;
            end
            default: ;  // B, C, D are reported only
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_freq_entry.sv
// tb_keypad_freq_entry
//   Directed bench for keypad_freq_entry: a behavioural 4x4 keypad pulls a
//   column low whenever its key is held and its row is driven low.
//   Tick every 10 clocks, 3-tick debounce.
module tb_keypad_freq_entry;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  col_in;
  logic [3:0]  row_out;
  logic [3:0]  key_code;
  logic        key_valid;
  logic [15:0] entry;
  logic [15:0] freq_set;
  logic        freq_set_valid;

  logic [15:0] key_down;
  int checks = 0;
  int errors = 0;
  int kv_count = 0;
  int fsv_count = 0;
  int base;

  always #5 clk = ~clk;

  keypad_freq_entry #(
    .CLK_HZ         (1000),
    .SCAN_HZ        (100),
    .DEBOUNCE_SCANS (3)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .col_in         (col_in),
    .row_out        (row_out),
    .key_code       (key_code),
    .key_valid      (key_valid),
    .entry          (entry),
    .freq_set       (freq_set),
    .freq_set_valid (freq_set_valid)
  );

  // Keypad model: key at (r,c) shorts row r to column c.
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (key_down[r*4+c] && !row_out[r]) col_in[c] = 1'b0;
  end

  always @(posedge clk) begin
    if (key_valid)      kv_count  <= kv_count + 1;
    if (freq_set_valid) fsv_count <= fsv_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic wait_kv(input string tag);
    int n = 0;
    while (key_valid !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_kv_seen"}, {31'd0, key_valid}, 32'd1);
  endtask

  // Returns at the negedge just after the tick that moved the row to target.
  task automatic wait_row(input logic [3:0] target, input string tag);
    int n = 0;
    while (row_out == target && n < 100) begin
      @(negedge clk);
      n++;
    end
    while (row_out != target && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_row_found"}, row_out, target);
  endtask

  task automatic press_key(input int r, input int c, input logic [3:0] code,
                           input logic [15:0] exp_entry, input string tag);
    key_down[r*4+c] = 1'b1;
    wait_kv(tag);
    check({tag, "_code"}, key_code, code);
    key_down[r*4+c] = 1'b0;
    repeat (60) @(negedge clk);
    check({tag, "_entry"}, entry, exp_entry);
  endtask

  initial begin
    rst      = 1'b1;
    key_down = '0;

    // 1: reset state and idle row rotation
    repeat (3) @(negedge clk);
    check("rst_row",   row_out, 4'b1110);
    check("rst_code",  key_code, 4'h0);
    check("rst_kv",    key_valid, 1'b0);
    check("rst_entry", entry, 16'd0);
    check("rst_fset",  freq_set, 16'd0);
    check("rst_fsv",   freq_set_valid, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rot_1", row_out, 4'b1101);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("rot_2", row_out, 4'b1011);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("rot_3", row_out, 4'b0111);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("rot_4", row_out, 4'b1110);

    // 2: press key 5 (r1c1), hold, release
    key_down[5] = 1'b1;
    wait_kv("t2");
    check("t2_code", key_code, 4'h5);
    repeat (60) @(negedge clk);
    check("t2_row_held", row_out, 4'b1101);
    check("t2_entry", entry, 16'd5);
    check("t2_kv_once", kv_count, 32'd1);
    key_down[5] = 1'b0;
    repeat (60) @(negedge clk);
    check("t2_kv_after_rel", kv_count, 32'd1);

    // 3: bounce on key 5: low 2 ticks, high 1, low 5
    base = kv_count;
    wait_row(4'b1101, "t3");
    key_down[5] = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    key_down[5] = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    key_down[5] = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("t3_no_early_kv", kv_count, base);
    check("t3_row_held", row_out, 4'b1101);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("t3_kv_on_3rd", key_valid, 1'b1);
    repeat (20) @(negedge clk);
    key_down[5] = 1'b0;
    repeat (60) @(negedge clk);
    check("t3_kv_once", kv_count, base + 1);
    check("t3_entry", entry, 16'd55);

    // 4: clear, digit entry with overflow, backspace, B, enter, edge cases
    press_key(0, 3, 4'hA, 16'd0,    "t4_clr");
    press_key(0, 0, 4'h1, 16'd1,    "t4_d1");
    press_key(0, 1, 4'h2, 16'd12,   "t4_d2");
    press_key(0, 2, 4'h3, 16'd123,  "t4_d3");
    press_key(1, 0, 4'h4, 16'd1234, "t4_d4");
    press_key(1, 1, 4'h5, 16'd1234, "t4_d5_ignored");
    press_key(3, 0, 4'hE, 16'd123,  "t4_bksp");
    press_key(1, 3, 4'hB, 16'd123,  "t4_b_noop");
    press_key(3, 2, 4'hF, 16'd0,    "t4_enter");
    check("t4_fset", freq_set, 16'd123);
    check("t4_fsv_once", fsv_count, 32'd1);
    press_key(3, 0, 4'hE, 16'd0,    "t4_bksp_empty");
    press_key(3, 2, 4'hF, 16'd0,    "t4_enter_empty");
    check("t4_fset_zero", freq_set, 16'd0);
    check("t4_fsv_twice", fsv_count, 32'd2);

    // 5: ghosting on row 0 (keys 1 and 2 together)
    base = kv_count;
    key_down[0] = 1'b1;
    key_down[1] = 1'b1;
    wait_row(4'b1110, "t5");
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("t5_rot_past_r0", row_out, 4'b1101);
    repeat (30) @(posedge clk);
    @(negedge clk);
    check("t5_back_r0", row_out, 4'b1110);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("t5_rot_again", row_out, 4'b1101);
    check("t5_no_kv", kv_count, base);
    key_down = '0;
    repeat (20) @(negedge clk);

    // 6: reset while key 7 (r2c0) is held in PRESSED
    base = kv_count;
    key_down[8] = 1'b1;
    wait_kv("t6");
    check("t6_code", key_code, 4'h7);
    repeat (20) @(negedge clk);
    check("t6_entry_pre", entry, 16'd7);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("t6_rst_row", row_out, 4'b1110);
    check("t6_rst_entry", entry, 16'd0);
    check("t6_rst_code", key_code, 4'h0);
    rst = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("t6_no_kv_early", key_valid, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("t6_kv_redetect", key_valid, 1'b1);
    check("t6_code_redetect", key_code, 4'h7);
    @(negedge clk);
    check("t6_entry_post", entry, 16'd7);
    key_down = '0;
    repeat (60) @(negedge clk);
    check("t6_kv_total", kv_count, base + 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
